mux2_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 2:1 mux output channel between two requesters.
- Grants one requester at a time and drives the mux select.
- Holds the grant across a burst of beats, up to a configured maximum, and releases on last beat, burst limit, or request drop.
- Sits in front of a downstream consumer that has a valid/ready input.

---
 rtl/mux_arb_pkg.sv | 26 ++
 rtl/mux2to1_dw.sv | 16 +
 rtl/mux2_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_arb_pkg;

  // Default data width of each requester and of the muxed output.
  localparam int DEF_DW        = 8;
  // Default maximum beats per grant before a forced handover (legal 1..15).
  localparam int DEF_MAX_BURST = 4;
  // The beat counter never reaches 16 because release happens at MAX_BURST.
  localparam int BEAT_CNT_W    = 4;
  // Width of the optional per-requester beat statistics counters.
  localparam int STAT_W        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Ownership state for a requester index (0 -> OWN0, 1 -> OWN1).
  function automatic arb_state_t own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mux2to1_dw.sv
// Parameterized DW-wide 2:1 data multiplexer.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
// Ports: sel (0 picks in0, 1 picks in1), in0/in1 data inputs, out muxed data.
module mux2to1_dw #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  output logic [DW-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux output between two requesters,
// holding a grant for a burst of up to MAX_BURST beats.
// Latency: 1 cycle req->gnt from IDLE; zero-bubble handover between owners.
// Backpressure: out_ready=0 freezes state, beat count and sel; no timeout.
// Ports: clk, rst_n (async active-low); req0/req1, data0/data1, last0/last1
// from the requesters; gnt0/gnt1 and sel (registered); out_valid/out_data
// (combinational) with out_ready from the consumer. Optional macro
// ARB_STATS_EN adds cnt0/cnt1 saturating per-requester beat counters.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DW-1:0]     data0,
  input  logic [DW-1:0]     data1,
  input  logic              last0,
  input  logic              last1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  input  logic              out_ready
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt0,
  output logic [STAT_W-1:0] cnt1
`endif
);

  // Beat count value that ends a burst; MAX_BURST is limited to 1..15.
  localparam logic [BEAT_CNT_W-1:0] BURST_END = BEAT_CNT_W'(MAX_BURST);

  arb_state_t            state, state_n;
  logic                  sel_n;
  logic                  ptr, ptr_n;       // 0 favours requester 0
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_n, beat_cnt_inc;

  // Signals viewed from the current owner's point of view.
  logic own_id;
  logic own_req;
  logic own_last;
  logic other_req;
  logic fire;
  logic drop;
  logic done;

  assign own_id    = (state == OWN1);
  assign own_req   = own_id ? req1  : req0;
  assign own_last  = own_id ? last1 : last0;
  assign other_req = own_id ? req0  : req1;

  assign gnt0      = (state == OWN0);
  assign gnt1      = (state == OWN1);
  assign out_valid = (gnt0 && req0) || (gnt1 && req1);
  assign fire      = out_valid && out_ready;

  assign beat_cnt_inc = beat_cnt + 1'b1;
  // A drop releases without a beat; done releases on a beat that ends the burst.
  assign drop = (state != IDLE) && !own_req;
  assign done = fire && (own_last || (beat_cnt_inc == BURST_END));

  mux2to1_dw #(
    .DW (DW)
  ) u_data_mux (
    .sel (sel),
    .in0 (data0),
    .in1 (data1),
    .out (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      ptr      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;

    case (state)
      IDLE: begin
        beat_cnt_n = '0;
        if (req0 && req1) begin
          state_n = own_state(ptr);
          sel_n   = ptr;
        end else if (req0) begin
          state_n = OWN0;
          sel_n   = 1'b0;
        end else if (req1) begin
          state_n = OWN1;
          sel_n   = 1'b1;
        end
      end

      OWN0, OWN1: begin
        if (drop || done) begin
          // Every release hands priority to the other requester. The other
          // side wins immediately if it is waiting; otherwise a requester that
          // finished (not dropped) keeps the channel for a fresh burst.
          ptr_n      = ~own_id;
          beat_cnt_n = '0;
          if (other_req) begin
            state_n = own_state(~own_id);
            sel_n   = ~own_id;
          end else if (!drop) begin
            state_n = own_state(own_id);
            sel_n   = own_id;
          end else begin
            state_n = IDLE;
          end
        end else if (fire) begin
          beat_cnt_n = beat_cnt_inc;
        end
      end

      default: begin
        state_n    = IDLE;
        beat_cnt_n = '0;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // Per-requester beat counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (fire) begin
      if (!own_id && (cnt0 != '1)) begin
        cnt0 <= cnt0 + 1'b1;
      end
      if (own_id && (cnt1 != '1)) begin
        cnt1 <= cnt1 + 1'b1;
      end
    end
  end
`else
  // Statistics build option disabled: no beat counters are implemented.
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus random
// traffic, checked every cycle against a behavioural reference model.
// Optional macro ARB_STATS_EN enables the statistics counter checks.
module tb_mux2_rr_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, last0, last1, out_ready;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, sel, out_valid;
  logic [DW-1:0] out_data;
`ifdef ARB_STATS_EN
  logic [15:0]   cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  mux2_rr_arbiter #(
    .DW        (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .last0     (last0),
    .last1     (last1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef ARB_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the channel (-1 none), beats in this burst,
  // which requester is favoured, the mux select, and beats fired per side.
  int   m_owner;
  int   m_beats;
  int   m_fav;
  logic m_sel;
  int   m_fired0;
  int   m_fired1;
  int   last_fire;   // requester whose beat fired in the last tick, or -1

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_beats  = 0;
    m_fav    = 0;
    m_sel    = 1'b0;
    m_fired0 = 0;
    m_fired1 = 0;
  endtask

  task automatic take(input int who);
    m_owner = who;
    m_sel   = (who == 1);
    m_beats = 0;
  endtask

  // Called at a falling edge with inputs already driven: check outputs,
  // advance the model by one clock, and return at the next falling edge.
  task automatic tick();
    logic e_valid, e_fire, mine, mine_last, other_r, drop, done;
    #1;
    e_valid = (m_owner == 0 && req0) || (m_owner == 1 && req1);
    chk1("gnt0", gnt0, m_owner == 0);
    chk1("gnt1", gnt1, m_owner == 1);
    chk1("sel", sel, m_sel);
    chk1("out_valid", out_valid, e_valid);
    chk32("out_data", 32'(out_data), 32'(m_sel ? data1 : data0));
`ifdef ARB_STATS_EN
    chk32("cnt0", 32'(cnt0), 32'(m_fired0));
    chk32("cnt1", 32'(cnt1), 32'(m_fired1));
`endif
    e_fire    = e_valid && out_ready;
    last_fire = e_fire ? m_owner : -1;
    if (m_owner < 0) begin
      if (req0 && req1) take(m_fav);
      else if (req0)    take(0);
      else if (req1)    take(1);
    end else begin
      mine      = (m_owner == 0) ? req0  : req1;
      mine_last = (m_owner == 0) ? last0 : last1;
      other_r   = (m_owner == 0) ? req1  : req0;
      drop      = !mine;
      done      = 1'b0;
      if (e_fire) begin
        m_beats++;
        if (m_owner == 0) m_fired0++;
        else              m_fired1++;
        done = mine_last || (m_beats == MB);
      end
      if (drop || done) begin
        m_fav   = 1 - m_owner;
        m_beats = 0;
        if (other_r)   m_owner = 1 - m_owner;
        else if (drop) m_owner = -1;
        if (m_owner >= 0) m_sel = (m_owner == 1);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n0, f0, f1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    data0 = '0; data1 = '0; out_ready = 1'b1;
    model_reset();
    last_fire = -1;
    #1;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_sel", sel, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, last on the third beat, then it stops requesting.
    req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
    n0 = 0;
    for (int i = 0; i < 7; i++) begin
      if (n0 == 2) last0 = 1'b1;
      if (n0 == 3) begin req0 = 1'b0; last0 = 1'b0; end
      tick();
      if (i == 0) chk1("s1_gnt0_latency", gnt0, 1'b1);
      if (last_fire == 0) n0++;
    end
    chk32("s1_beats", 32'(n0), 32'd3);
    chk1("s1_idle_gnt0", gnt0, 1'b0);

    // Contention: both requesting continuously, no last.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    tick();
    f0 = 0; f1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (last_fire == 0) f0++;
      if (last_fire == 1) f1++;
    end
    chk32("s2_beats0", 32'(f0), 32'd8);
    chk32("s2_beats1", 32'(f1), 32'd8);

    // Backpressure mid-burst while requester 1 owns the channel.
    req0 = 1'b0; data1 = 8'h3C;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("s3_gnt1_hold", gnt1, 1'b1);
      chk1("s3_sel_hold", sel, 1'b1);
      chk32("s3_data_hold", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1; req0 = 1'b1;
    tick();
    chk32("s3_fire_after_ready", 32'(last_fire), 32'd1);
    tick();
    chk1("s3_handover_gnt0", gnt0, 1'b1);

    // Drop: requester 0 owns after one beat, then lets go while 1 waits.
    tick();
    req0 = 1'b0;
    tick();
    chk1("s4_gnt1", gnt1, 1'b1);
    chk1("s4_gnt0", gnt0, 1'b0);
    req1 = 1'b0;
    tick();

    // Reset in the middle of a requester-1 burst.
    req1 = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk1("s5_gnt1_async", gnt1, 1'b0);
    chk1("s5_valid_async", out_valid, 1'b0);
    chk1("s5_sel_async", sel, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk1("s5_first_gnt0", gnt0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 3) != 0);
      last0     = ($urandom_range(0, 3) == 0);
      last1     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data0     = 8'($urandom);
      data1     = 8'($urandom);
      tick();
    end

`ifdef ARB_STATS_EN
    // Six beats from requester 0, three from requester 1, then reset.
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    last0 = 1'b0; last1 = 1'b0; out_ready = 1'b1;
    f0 = 0; f1 = 0;
    for (int i = 0; i < 30; i++) begin
      req0 = (f0 < 6);
      req1 = (f0 >= 6) && (f1 < 3);
      tick();
      if (last_fire == 0) f0++;
      if (last_fire == 1) f1++;
    end
    chk32("stats_cnt0", 32'(cnt0), 32'd6);
    chk32("stats_cnt1", 32'(cnt1), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk32("stats_cnt0_rst", 32'(cnt0), 32'd0);
    chk32("stats_cnt1_rst", 32'(cnt1), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
